// File: rtl/iic_pkg.sv
// Shared types for the IIC byte master: FSM states, SCL quarter index and
// the read/write direction encoding used in the address byte.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE, START, DEV_W, REG, WDATA, RSTART, DEV_R, RDATA, MNACK, ACK, STOP
    } state_t;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/iic_quarter_timer.sv
// Divides clk into SCL quarter periods: a running quarter index plus a strobe
// on the last cycle of each quarter. Held at Q0/count 0 while in reset.
import iic_pkg::*;

module iic_quarter_timer #(
    parameter int DIV_QUARTER = 125
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] q_idx,
    output logic       q_end
);

    logic [11:0] cnt;

    assign q_end = (cnt == 12'(DIV_QUARTER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            q_idx <= Q0;
        end else if (q_end) begin
            cnt   <= '0;
            q_idx <= q_idx + 2'd1;
        end else begin
            cnt   <= cnt + 12'd1;
        end
    end

endmodule

// File: rtl/iic_byte_master.sv
// Single-transaction I2C master: one register write or read per request,
// gated by a qualified PLL lock and aborted without STOP if lock is lost.
import iic_pkg::*;

module iic_byte_master #(
    parameter int DIV_QUARTER = 125,
    parameter int LOCK_WAIT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_abort,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    state_t      state, state_next, ack_from;
    quarter_t    quarter;
    logic [1:0]  q_idx;
    logic        q_end, bit_end, q2_end, idle, accept, lock_lost, lock_ok, scl_low;
    logic [15:0] lock_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg, reg_r, wdata_r;
    logic [6:0]  dev_r;
    logic        rw_r, smp, nack_flag;

    assign idle      = (state == IDLE);
    assign busy      = !idle;
    assign lock_ok   = pll_lock && (lock_cnt == 16'(LOCK_WAIT));
    assign req_ready = lock_ok && idle && !rsp_valid;
    assign accept    = req_valid && req_ready;
    assign lock_lost = busy && !pll_lock;
    assign quarter   = quarter_t'(q_idx);
    assign bit_end   = q_end && (quarter == Q3);
    assign q2_end    = q_end && (quarter == Q2);
    assign scl_low   = (quarter == Q0) || (quarter == Q1);

    iic_quarter_timer #(.DIV_QUARTER(DIV_QUARTER)) u_timer (
        .clk   (clk),
        .rst   (rst || idle),
        .q_idx (q_idx),
        .q_end (q_end)
    );

    always_ff @(posedge clk) begin
        if (rst || !pll_lock)
            lock_cnt <= '0;
        else if (lock_cnt != 16'(LOCK_WAIT))
            lock_cnt <= lock_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = START;
            START:  if (bit_end) state_next = DEV_W;
            DEV_W, REG, WDATA, DEV_R:
                    if (bit_end && bit_cnt == 3'd7) state_next = ACK;
            RDATA:  if (bit_end && bit_cnt == 3'd7) state_next = MNACK;
            ACK: begin
                if (bit_end) begin
                    if (smp) begin
                        state_next = STOP;
                    end else begin
                        case (ack_from)
                            DEV_W:   state_next = REG;
                            REG:     state_next = (rw_r == RW_READ) ? RSTART : WDATA;
                            DEV_R:   state_next = RDATA;
                            default: state_next = STOP;
                        endcase
                    end
                end
            end
            RSTART: if (bit_end) state_next = DEV_R;
            MNACK:  if (bit_end) state_next = STOP;
            STOP:   if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (lock_lost) state_next = IDLE;
    end

    // Open-drain drive: 1 pulls the line low.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            START: begin
                sda_oe = !scl_low;
            end
            RSTART: begin
                scl_oe = (quarter == Q0);
                sda_oe = !scl_low;
            end
            STOP: begin
                scl_oe = (quarter == Q0);
                sda_oe = scl_low;
            end
            DEV_W, REG, WDATA, DEV_R: begin
                scl_oe = scl_low;
                sda_oe = !shreg[7];
            end
            ACK, RDATA, MNACK: begin
                scl_oe = scl_low;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rw_r      <= req_rw;
            dev_r     <= req_dev_addr;
            reg_r     <= req_reg_addr;
            wdata_r   <= req_wdata;
            nack_flag <= 1'b0;
        end
        if (q2_end)
            smp <= sda_i;
        if (bit_end) begin
            bit_cnt <= (state_next != state) ? 3'd0 : bit_cnt + 3'd1;
            if (state == ACK && smp)
                nack_flag <= 1'b1;
            if (state_next == ACK && state != ACK)
                ack_from <= state;
            // Load on entry to a transmit byte; otherwise shift, capturing the
            // sampled bit so a finished RDATA leaves the received byte here.
            if (state_next != state) begin
                case (state_next)
                    DEV_W:   shreg <= {dev_r, RW_WRITE};
                    REG:     shreg <= reg_r;
                    WDATA:   shreg <= wdata_r;
                    DEV_R:   shreg <= {dev_r, RW_READ};
                    default: if (state == RDATA) shreg <= {shreg[6:0], smp};
                endcase
            end else begin
                shreg <= {shreg[6:0], smp};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_abort <= 1'b0;
        end else if (lock_lost) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_abort <= 1'b1;
        end else if (state == STOP && bit_end) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (rw_r == RW_READ && !nack_flag) ? shreg : 8'd0;
            rsp_nack  <= nack_flag;
            rsp_abort <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iic_byte_master.sv
// Directed bench for iic_byte_master with a behavioural I2C slave that logs
// START/STOP and every 9-bit frame seen on the wired-AND bus.
module tb_iic_byte_master;

    logic       clk = 1'b0, rst = 1'b1, pll_lock = 1'b0;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [6:0] req_dev_addr = '0;
    logic [7:0] req_reg_addr = '0, req_wdata = '0;
    logic       req_ready, rsp_valid, rsp_nack, rsp_abort, busy, scl_oe, sda_oe, sda_i;
    logic [7:0] rsp_rdata;

    logic slave_oe = 1'b0;
    logic scl, sda;
    assign scl   = !scl_oe;
    assign sda   = !sda_oe && !slave_oe;
    assign sda_i = sda;

    int ntest = 0, nfail = 0, cyc = 0;
    int exp_log[$];
    int slv_log[$];

    iic_byte_master #(.DIV_QUARTER(4), .LOCK_WAIT(8)) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_abort(rsp_abort), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: ACKs master bytes (optionally NACKs the first address byte),
    // returns rd_byte after an ACKed read address. Log: 0x200 START, 0x300 STOP,
    // otherwise {ninth bit, byte}.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, first = 1'b0;
    logic       rd_pend = 1'b0, rd_act = 1'b0, nack_addr = 1'b0, slv_clr = 1'b0;
    logic [7:0] cur = '0, rd_byte = 8'h3C;
    int         bitn = 0;

    always @(posedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda;
        if (slv_clr) begin
            bitn <= 0; first <= 1'b0; rd_pend <= 1'b0; rd_act <= 1'b0;
            slave_oe <= 1'b0; cur <= '0;
            slv_log.delete();
        end else if (prev_scl && scl && prev_sda && !sda) begin
            bitn <= 0; first <= 1'b1; cur <= '0; rd_pend <= 1'b0; rd_act <= 1'b0;
            slv_log.push_back(32'h200);
        end else if (prev_scl && scl && !prev_sda && sda) begin
            bitn <= 0; rd_act <= 1'b0;
            slv_log.push_back(32'h300);
        end else if (!prev_scl && scl) begin
            if (bitn < 8) begin
                cur <= {cur[6:0], sda};
            end else begin
                slv_log.push_back(int'({sda, cur}));
                if (first && cur[0] && !sda) rd_pend <= 1'b1;
            end
            bitn <= bitn + 1;
        end else if (prev_scl && !scl) begin
            if (bitn == 9) begin
                bitn  <= 0;
                first <= 1'b0;
                if (rd_pend) begin
                    rd_pend  <= 1'b0;
                    rd_act   <= 1'b1;
                    slave_oe <= !rd_byte[7];
                end else begin
                    rd_act   <= 1'b0;
                    slave_oe <= 1'b0;
                end
            end else if (bitn == 8) begin
                slave_oe <= rd_act ? 1'b0 : !(first && nack_addr);
            end else if (rd_act && bitn > 0) begin
                slave_oe <= !rd_byte[7 - bitn];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntest++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, slv_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < slv_log.size(); i++)
            chk($sformatf("%s_%0d", tag, i), slv_log[i], exp_log[i]);
    endtask

    task automatic start_txn(input string tag, input logic rw, input logic [6:0] dev,
                             input logic [7:0] ra, input logic [7:0] wd, output int t_acc);
        int n;
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
        t_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = 8'hFF;
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic wait_rsp(input int t_acc, output int lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        lat = rsp_valid ? (cyc - t_acc) : -1;
    endtask

    int t_acc, lat, c0, pulses;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bus", {scl_oe, sda_oe}, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_nack, rsp_abort, rsp_rdata}, 11'h0);
        rst = 1'b0;

        // Lock qualification, including a restart after a short drop
        @(negedge clk);
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        chk("lock_partial", req_ready, 1'b0);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        c0 = cyc;
        repeat (7) @(negedge clk);
        chk("lock_7", req_ready, 1'b0);
        @(negedge clk);
        chk("lock_8", req_ready, 1'b1);
        chk("lock_cyc", cyc - c0, 8);

        // Write with ACKing slave
        start_txn("wr", 1'b0, 7'h50, 8'h10, 8'hA5, t_acc);
        wait_rsp(t_acc, lat);
        chk("wr_lat", lat, 465);
        chk("wr_nack", rsp_nack, 1'b0);
        chk("wr_abort", rsp_abort, 1'b0);
        chk("wr_rdata", rsp_rdata, 8'h00);
        chk("wr_ready_in_rsp", req_ready, 1'b0);
        chk("wr_busy_in_rsp", busy, 1'b0);
        exp_log = {32'h200, 32'h0A0, 32'h010, 32'h0A5, 32'h300};
        chk_log("wr_log");
        @(negedge clk);
        chk("wr_ready_after", req_ready, 1'b1);

        // Read, slave returns 0x3C, master NACKs the data byte
        start_txn("rd", 1'b1, 7'h50, 8'h22, 8'h00, t_acc);
        wait_rsp(t_acc, lat);
        chk("rd_lat", lat, 625);
        chk("rd_rdata", rsp_rdata, 8'h3C);
        chk("rd_nack", rsp_nack, 1'b0);
        exp_log = {32'h200, 32'h0A0, 32'h022, 32'h200, 32'h0A1, 32'h13C, 32'h300};
        chk_log("rd_log");

        // Device address NACKed
        nack_addr = 1'b1;
        start_txn("nk", 1'b0, 7'h50, 8'h10, 8'h77, t_acc);
        wait_rsp(t_acc, lat);
        chk("nk_lat", lat, 177);
        chk("nk_nack", rsp_nack, 1'b1);
        chk("nk_rdata", rsp_rdata, 8'h00);
        exp_log = {32'h200, 32'h1A0, 32'h300};
        chk_log("nk_log");
        nack_addr = 1'b0;

        // Lock lost during the register byte
        start_txn("ab", 1'b0, 7'h50, 8'h10, 8'hA5, t_acc);
        while (cyc < t_acc + 198) @(negedge clk);
        chk("ab_pre_scl", scl_oe, 1'b1);
        pll_lock = 1'b0;
        @(negedge clk);
        chk("ab_bus", {scl_oe, sda_oe}, 2'b00);
        chk("ab_busy", busy, 1'b0);
        chk("ab_valid", rsp_valid, 1'b1);
        chk("ab_abort", rsp_abort, 1'b1);
        chk("ab_nack_rdata", {rsp_nack, rsp_rdata}, 9'h0);
        pll_lock = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("ab_valid_drop", rsp_valid, 1'b0);
        repeat (6) @(negedge clk);
        chk("ab_relock_7", req_ready, 1'b0);
        @(negedge clk);
        chk("ab_relock_8", req_ready, 1'b1);
        chk("ab_relock_cyc", cyc - c0, 8);

        // Reset in the middle of a read, then a normal write
        start_txn("rr", 1'b1, 7'h50, 8'h22, 8'h00, t_acc);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_bus", {scl_oe, sda_oe}, 2'b00);
        chk("rr_busy_ready", {busy, req_ready}, 2'b00);
        chk("rr_rsp", {rsp_valid, rsp_nack, rsp_abort, rsp_rdata}, 11'h0);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("rr_no_rsp", pulses, 0);
        start_txn("wr2", 1'b0, 7'h2D, 8'h33, 8'h5A, t_acc);
        wait_rsp(t_acc, lat);
        chk("wr2_lat", lat, 465);
        chk("wr2_nack_abort", {rsp_nack, rsp_abort}, 2'b00);
        exp_log = {32'h200, 32'h05A, 32'h033, 32'h05A, 32'h300};
        chk_log("wr2_log");

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", ntest);
        $fatal(1, "watchdog");
    end

endmodule
